// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//
// 8N1 UART transmitter fed by a byte FIFO. A producer pushes bytes with a
// valid/ready handshake; the serializer pops them in order and sends each one
// as a start bit, eight data bits LSB first and a stop bit, every bit lasting
// CLKS_PER_BIT clocks. Frames are sent back to back while the FIFO holds data.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   FIFO_DEPTH   : byte FIFO entries (power of 2, >= 2)
//
// Ports
//   i_clk    : clock, everything on the rising edge
//   i_rst    : synchronous active-high reset
//   i_wdata  : byte offered by the producer
//   i_wvalid : producer has a byte on i_wdata
//   o_wready : a byte can be accepted this cycle (FIFO not full, not in reset)
//   o_tx     : registered serial line, idle high
//   o_busy   : FIFO non-empty or a frame in progress
//   o_level  : current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [7:0]                  i_wdata,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage and pointers
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Serializer
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;

    logic             push;
    logic             pop;
    logic             bit_done;
    logic [7:0]       head;

    assign o_wready = !i_rst && (level_q < LVL_FULL);
    assign push     = i_wvalid && o_wready;
    assign bit_done = (cnt_q == CNT_LAST);
    assign head     = mem_q[rd_ptr_q];

    // A pop happens when the serializer wants a new byte: straight from IDLE,
    // or on the last cycle of STOP so consecutive frames have no idle gap.
    // The empty test uses the occupancy before this edge's push, so a byte
    // pushed on the same edge is never the one popped.
    assign pop = (level_q != '0) &&
                 ((state_q == IDLE) || ((state_q == STOP) && bit_done));

    assign o_tx    = tx_q;
    assign o_level = level_q;
    assign o_busy  = (state_q != IDLE) || (level_q != '0);

    // -----------------------------------------------------------------------
    // FIFO bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Pointers wrap naturally because FIFO_DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the values from before this edge.
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; clearing the
    // pointers and level already makes its contents unreachable.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Serializer FSM, o_tx registered
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    tx_q  <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // The line shows shift_q[0]; the next bit is [1].
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (pop) begin
                            shift_q <= head;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Self-checking bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A reference model keeps the FIFO as a queue and the frame in flight as a
// position 0..39 inside a 40-cycle frame; the expected line level is derived
// from that position. Captured line samples are also decoded into bytes and
// compared against the bytes the bench offered.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] wdata  = 8'h00;
    logic       wvalid = 1'b0;
    logic       wready;
    logic       tx;
    logic       busy;
    logic [4:0] level;

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_wdata (wdata),
        .i_wvalid(wvalid),
        .o_wready(wready),
        .o_tx    (tx),
        .o_busy  (busy),
        .o_level (level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    byte unsigned m_q[$];
    bit           m_active = 1'b0;
    int           m_pos    = 0;
    byte unsigned m_cur    = 8'h00;

    // Observation
    int           n_acc = 0;
    byte unsigned acc_q[$];
    logic         cap[$];
    int           rx_start[$];
    byte unsigned rx_byte[$];
    bit           rx_ok[$];
    byte unsigned exp_q[$];

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       tx;
        logic [4:0] lvl;
        logic       rdy;
        logic       bsy;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model, given the inputs held before it.
    function automatic void model_step(input logic r, input logic v, input logic [7:0] d);
        bit push;
        bit pop;
        bit done;
        if (r) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            return;
        end
        push = v && (m_q.size() < DEPTH);
        done = m_active && (m_pos == FRAME - 1);
        pop  = (m_q.size() != 0) && (!m_active || done);
        if (m_active && !done) m_pos++;
        if (done) m_active = 1'b0;
        if (pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (push) m_q.push_back(d);
    endfunction

    function automatic logic model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    // Drive inputs, clock once, compare every output against the model.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        rst    = r;
        wvalid = v;
        wdata  = d;
        #1;
        if (v && wready) begin
            n_acc++;
            acc_q.push_back(d);
        end
        @(posedge clk);
        model_step(r, v, d);
        #1;
        cap.push_back(tx);
        check("tx", tx, model_tx());
        check("level", level, m_q.size());
        check("busy", busy, (m_active || m_q.size() != 0));
        check("wready", wready, (!r && m_q.size() < DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        rst    = v.r;
        wvalid = v.v;
        wdata  = v.d;
        @(posedge clk);
        model_step(v.r, v.v, v.d);
        #1;
        check($sformatf("tbl%0d_tx", idx), tx, v.tx);
        check($sformatf("tbl%0d_level", idx), level, v.lvl);
        check($sformatf("tbl%0d_wready", idx), wready, v.rdy);
        check($sformatf("tbl%0d_busy", idx), busy, v.bsy);
    endtask

    // Decode captured line samples into frames; a frame is well formed when
    // every bit is steady for CPB samples, starts low and stops high.
    task automatic decode();
        int         i;
        logic [7:0] b;
        bit         ok;
        rx_start.delete();
        rx_byte.delete();
        rx_ok.delete();
        i = 0;
        while (i < cap.size()) begin
            if (cap[i] === 1'b0 && (i + FRAME) <= cap.size()) begin
                ok = 1'b1;
                b  = 8'h00;
                for (int k = 0; k < 10; k++) begin
                    for (int s = 0; s < CPB; s++) begin
                        if (cap[i + k*CPB + s] !== cap[i + k*CPB]) ok = 1'b0;
                    end
                    if (k >= 1 && k <= 8) b[k-1] = cap[i + k*CPB];
                end
                if (cap[i + 9*CPB] !== 1'b1) ok = 1'b0;
                rx_start.push_back(i);
                rx_byte.push_back(b);
                rx_ok.push_back(ok);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    task automatic expect_frames(input string name);
        decode();
        check($sformatf("%s_count", name), rx_byte.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < rx_byte.size(); j++) begin
            check($sformatf("%s_byte%0d", name, j), rx_byte[j], exp_q[j]);
            check($sformatf("%s_form%0d", name, j), rx_ok[j], 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_a5[10];
        logic exp_bit;
        int   dens;
        int   bad_cycles;
        bit   found;
        logic r;
        logic v;
        logic [7:0] d;

        // ---------------- table-driven reset / first transfer -------------
        //            r     v     d      tx    lvl   rdy   bsy
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 5'd1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'h77, 1'b0, 5'd0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'h5A, 1'b0, 5'd1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd2, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 8'h22, 1'b1, 5'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0};
        #1;
        for (int i = 0; i < 8; i++) apply_vec(tbl[i], i);
        idle(3);

        // ---------------- single byte 0xA5 --------------------------------
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        cap.delete();
        cycle(1'b0, 1'b1, 8'hA5);
        idle(45);
        for (int j = 0; j < FRAME; j++) begin
            check($sformatf("a5_line%0d", j), cap[1 + j], exp_a5[j / CPB]);
        end
        check("a5_busy_after", busy, 0);
        check("a5_level_after", level, 0);

        // ---------------- back-to-back 0x00, 0xFF ------------------------
        cap.delete();
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'hFF);
        idle(85);
        for (int j = 0; j < 84; j++) begin
            if (j < 36)      exp_bit = 1'b0;
            else if (j < 40) exp_bit = 1'b1;
            else if (j < 44) exp_bit = 1'b0;
            else             exp_bit = 1'b1;
            check($sformatf("b2b_line%0d", j), cap[1 + j], exp_bit);
        end
        check("b2b_busy_after", busy, 0);

        // ---------------- fill the FIFO ----------------------------------
        cap.delete();
        acc_q.delete();
        n_acc = 0;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i));
        check("full_accepted", n_acc, 17);
        check("full_level", level, 16);
        check("full_wready", wready, 0);
        for (int i = 20; i < 50; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i));
        check("full_refill_accepted", n_acc, 18);
        check("full_refill_level", level, 16);
        idle(18 * FRAME + 10);
        exp_q = acc_q;
        expect_frames("full");

        // ---------------- ordering 0x01..0x10 -----------------------------
        cap.delete();
        for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 8'(i));
        idle(16 * FRAME + 10);
        exp_q.delete();
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        expect_frames("order");
        for (int j = 1; j < rx_start.size(); j++) begin
            check($sformatf("order_gap%0d", j), rx_start[j] - rx_start[j-1], FRAME);
        end

        // ---------------- reset mid-frame --------------------------------
        cycle(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'hD0 + i));
        idle(4);
        check("rst_level_before", level, 5);
        cycle(1'b1, 1'b0, 8'h00);
        check("rst_tx", tx, 1);
        check("rst_level", level, 0);
        bad_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            if (tx !== 1'b1 || busy !== 1'b0) bad_cycles++;
        end
        check("rst_quiet_cycles", bad_cycles, 0);

        // ---------------- first byte after reset --------------------------
        cap.delete();
        cycle(1'b0, 1'b1, 8'h96);
        idle(45);
        exp_q.delete();
        exp_q.push_back(8'h96);
        expect_frames("post_rst");

        // ---------------- push on the edge STOP ends ----------------------
        cap.delete();
        cycle(1'b0, 1'b1, 8'hC3);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h5E);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_active && m_pos == FRAME - 1) found = 1'b1;
            else cycle(1'b0, 1'b0, 8'h00);
        end
        check("sp_reached_stop_end", found, 1);
        cycle(1'b0, 1'b1, 8'h81);
        check("sp_level", level, 1);
        check("sp_tx_start", tx, 0);
        idle(2 * FRAME + 10);
        exp_q.delete();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h5E);
        exp_q.push_back(8'h81);
        expect_frames("sp");

        // ---------------- randomized traffic against the model ------------
        dens = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dens = $urandom_range(0, 100);
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 99) < dens);
            d = 8'($urandom_range(0, 255));
            cycle(r, v, d);
        end
        idle(DEPTH * FRAME + 20);
        check("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
